// File: rtl/ncc_corr_row.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ncc_corr_row : parametrised 1-D systolic correlation row for NCC scoring  |
// | Revision     : 1.0                                                        |
// +---------------------------------------------------------------------------+
module ncc_corr_row #(
    parameter int NUM_PE   = 16,
    parameter int PIX_W    = 8,
    parameter int DESC_W   = 8,
    parameter int ACC_W    = 24,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [DESC_W-1:0] desc_data,
    input  logic              reload,
    input  logic              win_valid,
    output logic              win_ready,
    input  logic [PIX_W-1:0]  win_data,
    input  logic              win_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_score,
    output logic              out_sat
);

    typedef enum logic [0:0] {
        DESC_LOAD = 1'b0,
        RUN       = 1'b1
    } state_t;

    localparam int CNT_W = $clog2(NUM_PE + 1);
    localparam int LD_W  = $clog2(NUM_PE);
    localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(NUM_PE);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [LD_W-1:0]  C_LD_LAST  = LD_W'(NUM_PE - 1);
    localparam logic [ACC_W-1:0] C_ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] C_ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  r_state, w_state_next;
    logic [LD_W-1:0]         r_load_cnt;
    logic [CNT_W-1:0]        r_fill_cnt, w_fill_next;
    logic [DESC_W-1:0]       r_desc     [NUM_PE];
    logic [ACC_W-1:0]        r_acc      [NUM_PE];
    logic [ACC_W-1:0]        w_acc_next [NUM_PE];
    logic [NUM_PE-1:0]       r_sat, w_sat_next;
    logic                    w_desc_fire, w_win_fire, w_load_last, w_reload;

    assign w_load_last = (r_load_cnt == C_LD_LAST);
    assign w_desc_fire = desc_valid && desc_ready;
    assign w_win_fire  = win_valid && win_ready;
    assign w_reload    = (r_state == RUN) && reload;
    assign w_fill_next = win_clear ? C_ONE :
                         (r_fill_cnt == C_FULL) ? C_FULL : r_fill_cnt + C_ONE;

    always_comb begin
        w_state_next = r_state;
        desc_ready   = 1'b0;
        win_ready    = 1'b0;
        case (r_state)
            DESC_LOAD: begin
                desc_ready = 1'b1;
                if (desc_valid && w_load_last)
                    w_state_next = RUN;
            end
            RUN: begin
                // reload takes priority, so the concurrent sample is refused
                win_ready = (!out_valid || out_ready) && !reload;
                if (reload)
                    w_state_next = DESC_LOAD;
            end
            default: w_state_next = DESC_LOAD;
        endcase
    end

    generate
        for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
            logic [ACC_W-1:0] w_d_ext, w_x_ext, w_prod, w_prev;
            logic [ACC_W:0]   w_sum;
            logic             w_prev_sat, w_ovf;

            assign w_d_ext = {{(ACC_W-DESC_W){r_desc[k][DESC_W-1]}}, r_desc[k]};
            assign w_x_ext = {{(ACC_W-PIX_W){1'b0}}, win_data};
            assign w_prod  = ACC_W'($signed(w_d_ext) * $signed(w_x_ext));

            if (k == 0) begin : g_head
                assign w_prev     = '0;
                assign w_prev_sat = 1'b0;
            end else begin : g_link
                assign w_prev     = r_acc[k-1];
                assign w_prev_sat = r_sat[k-1];
            end

            // one guard bit: overflow when the two top bits disagree
            assign w_sum = {w_prev[ACC_W-1], w_prev} + {w_prod[ACC_W-1], w_prod};
            assign w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

            if (SATURATE) begin : g_sat
                assign w_acc_next[k] = !w_ovf ? w_sum[ACC_W-1:0] :
                                       (w_sum[ACC_W] ? C_ACC_MIN : C_ACC_MAX);
                assign w_sat_next[k] = w_prev_sat | w_ovf;
            end else begin : g_wrap
                assign w_acc_next[k] = w_sum[ACC_W-1:0];
                assign w_sat_next[k] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_desc_fire)
            r_desc[r_load_cnt] <= desc_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= DESC_LOAD;
            r_load_cnt <= '0;
            r_fill_cnt <= '0;
            r_sat      <= '0;
            out_valid  <= 1'b0;
            out_score  <= '0;
            out_sat    <= 1'b0;
            for (int k = 0; k < NUM_PE; k++)
                r_acc[k] <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_desc_fire)
                r_load_cnt <= w_load_last ? '0 : r_load_cnt + 1'b1;

            if (w_reload) begin
                r_fill_cnt <= '0;
                r_sat      <= '0;
                out_valid  <= 1'b0;
                for (int k = 0; k < NUM_PE; k++)
                    r_acc[k] <= '0;
            end else if (w_win_fire) begin
                r_fill_cnt <= w_fill_next;
                r_sat      <= w_sat_next;
                for (int k = 0; k < NUM_PE; k++)
                    r_acc[k] <= w_acc_next[k];
                if (w_fill_next == C_FULL) begin
                    out_score <= w_acc_next[NUM_PE-1];
                    out_sat   <= w_sat_next[NUM_PE-1];
                    out_valid <= 1'b1;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ncc_corr_row.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_ncc_corr_row : directed self-checking bench for ncc_corr_row           |
// | Revision        : 1.0                                                     |
// +---------------------------------------------------------------------------+
module tb_ncc_corr_row;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic desc_valid = 1'b0;
    logic [7:0] desc_data = '0;
    logic reload = 1'b0;
    logic win_valid = 1'b0;
    logic [7:0] win_data = '0;
    logic win_clear = 1'b0;
    logic out_ready = 1'b1;

    logic desc_ready_a, win_ready_a, out_valid_a, out_sat_a;
    logic desc_ready_s, win_ready_s, out_valid_s, out_sat_s;
    logic desc_ready_w, win_ready_w, out_valid_w, out_sat_w;
    logic signed [23:0] score_a;
    logic signed [16:0] score_s, score_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ncc_corr_row #(.NUM_PE(4), .PIX_W(8), .DESC_W(8), .ACC_W(24), .SATURATE(1'b1)) u_a (
        .clk(clk), .rst(rst), .desc_valid(desc_valid), .desc_ready(desc_ready_a),
        .desc_data(desc_data), .reload(reload), .win_valid(win_valid), .win_ready(win_ready_a),
        .win_data(win_data), .win_clear(win_clear), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_score(score_a), .out_sat(out_sat_a));

    ncc_corr_row #(.NUM_PE(4), .PIX_W(8), .DESC_W(8), .ACC_W(17), .SATURATE(1'b1)) u_s (
        .clk(clk), .rst(rst), .desc_valid(desc_valid), .desc_ready(desc_ready_s),
        .desc_data(desc_data), .reload(reload), .win_valid(win_valid), .win_ready(win_ready_s),
        .win_data(win_data), .win_clear(win_clear), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_score(score_s), .out_sat(out_sat_s));

    ncc_corr_row #(.NUM_PE(4), .PIX_W(8), .DESC_W(8), .ACC_W(17), .SATURATE(1'b0)) u_w (
        .clk(clk), .rst(rst), .desc_valid(desc_valid), .desc_ready(desc_ready_w),
        .desc_data(desc_data), .reload(reload), .win_valid(win_valid), .win_ready(win_ready_w),
        .win_data(win_data), .win_clear(win_clear), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_score(score_w), .out_sat(out_sat_w));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_desc(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] d [4];
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            desc_valid = 1'b1;
            desc_data  = d[i];
            step();
        end
        desc_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] x, input logic clr);
        win_valid = 1'b1;
        win_data  = x;
        win_clear = clr;
        for (int i = 0; i < 20 && win_ready_a !== 1'b1; i++) step();
        n_checks++;
        if (win_ready_a !== 1'b1) begin
            $display("FAIL send_timeout: win_ready=%b required 1", win_ready_a);
            n_fail++;
        end
        step();
        win_valid = 1'b0;
        win_clear = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks += 5;
        if ({desc_ready_a, desc_ready_s, desc_ready_w} !== 3'b111) begin
            $display("FAIL reset_desc_ready: got %b required 111", {desc_ready_a, desc_ready_s, desc_ready_w}); n_fail++; end
        if ({win_ready_a, win_ready_s, win_ready_w} !== 3'b000) begin
            $display("FAIL reset_win_ready: got %b required 000", {win_ready_a, win_ready_s, win_ready_w}); n_fail++; end
        if ({out_valid_a, out_valid_s, out_valid_w} !== 3'b000) begin
            $display("FAIL reset_out_valid: got %b required 000", {out_valid_a, out_valid_s, out_valid_w}); n_fail++; end
        if (score_a !== 24'sd0 || score_s !== 17'sd0) begin
            $display("FAIL reset_score: got %0d/%0d required 0", score_a, score_s); n_fail++; end
        if ({out_sat_a, out_sat_s, out_sat_w} !== 3'b000) begin
            $display("FAIL reset_sat: got %b required 000", {out_sat_a, out_sat_s, out_sat_w}); n_fail++; end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_stream();
        logic [7:0] xs [3];
        xs = '{8'd10, 8'd20, 8'd30};
        out_ready = 1'b1;
        load_desc(8'd1, 8'd2, 8'd3, 8'd4);
        for (int i = 0; i < 3; i++) begin
            send(xs[i], 1'b0);
            n_checks++;
            if (out_valid_a !== 1'b0) begin
                $display("FAIL stream_fill_valid: got %b required 0 at sample %0d", out_valid_a, i); n_fail++; end
        end
        send(8'd40, 1'b0);
        n_checks += 3;
        if (out_valid_a !== 1'b1) begin $display("FAIL stream_valid: got %b required 1", out_valid_a); n_fail++; end
        if (score_a !== 24'sd300) begin $display("FAIL stream_score300: got %0d required 300", score_a); n_fail++; end
        if (out_sat_a !== 1'b0) begin $display("FAIL stream_sat: got %b required 0", out_sat_a); n_fail++; end
        step();
        n_checks++;
        if (out_valid_a !== 1'b0) begin $display("FAIL stream_pulse: got %b required 0", out_valid_a); n_fail++; end
        send(8'd50, 1'b0);
        n_checks += 2;
        if (out_valid_a !== 1'b1) begin $display("FAIL stream_valid2: got %b required 1", out_valid_a); n_fail++; end
        if (score_a !== 24'sd400) begin $display("FAIL stream_score400: got %0d required 400", score_a); n_fail++; end
        step();
    endtask

    task automatic test_backpressure();
        do_reload();
        load_desc(8'd1, 8'd2, 8'd3, 8'd4);
        out_ready = 1'b1;
        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        send(8'd30, 1'b0);
        out_ready = 1'b0;
        send(8'd40, 1'b0);
        win_valid = 1'b1;
        win_data  = 8'd50;
        for (int i = 0; i < 5; i++) begin
            n_checks += 3;
            if (win_ready_a !== 1'b0) begin $display("FAIL bp_win_ready: got %b required 0 cycle %0d", win_ready_a, i); n_fail++; end
            if (out_valid_a !== 1'b1) begin $display("FAIL bp_valid: got %b required 1 cycle %0d", out_valid_a, i); n_fail++; end
            if (score_a !== 24'sd300) begin $display("FAIL bp_hold: got %0d required 300 cycle %0d", score_a, i); n_fail++; end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (win_ready_a !== 1'b1) begin $display("FAIL bp_release: win_ready=%b required 1", win_ready_a); n_fail++; end
        step();
        win_valid = 1'b0;
        n_checks += 2;
        if (out_valid_a !== 1'b1) begin $display("FAIL bp_valid2: got %b required 1", out_valid_a); n_fail++; end
        if (score_a !== 24'sd400) begin $display("FAIL bp_score400: got %0d required 400", score_a); n_fail++; end
        step();
        n_checks++;
        if (out_valid_a !== 1'b0) begin $display("FAIL bp_drain: got %b required 0", out_valid_a); n_fail++; end
    endtask

    task automatic test_row_clear();
        send(8'd7, 1'b1);
        send(8'd8, 1'b0);
        send(8'd9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send(8'd5, (i == 0));
            n_checks++;
            if (out_valid_a !== 1'b0) begin $display("FAIL clear_early_valid: got %b required 0 at sample %0d", out_valid_a, i); n_fail++; end
        end
        send(8'd5, 1'b0);
        n_checks += 2;
        if (out_valid_a !== 1'b1) begin $display("FAIL clear_valid: got %b required 1", out_valid_a); n_fail++; end
        if (score_a !== 24'sd50) begin $display("FAIL clear_score50: got %0d required 50", score_a); n_fail++; end
        step();
    endtask

    task automatic test_signed_sat();
        do_reload();
        load_desc(8'hFF, 8'd0, 8'd0, 8'd0);
        send(8'd255, 1'b0);
        send(8'd0, 1'b0);
        send(8'd0, 1'b0);
        send(8'd0, 1'b0);
        n_checks += 2;
        if (score_a !== -24'sd255) begin $display("FAIL signed_score: got %0d required -255", score_a); n_fail++; end
        if (out_sat_a !== 1'b0) begin $display("FAIL signed_sat: got %b required 0", out_sat_a); n_fail++; end
        do_reload();
        load_desc(8'd127, 8'd127, 8'd127, 8'd127);
        for (int i = 0; i < 4; i++) send(8'd255, 1'b0);
        n_checks += 6;
        if (score_s !== 17'sd65535) begin $display("FAIL sat_score: got %0d required 65535", score_s); n_fail++; end
        if (out_sat_s !== 1'b1) begin $display("FAIL sat_flag: got %b required 1", out_sat_s); n_fail++; end
        if (score_w !== -17'sd1532) begin $display("FAIL wrap_score: got %0d required -1532", score_w); n_fail++; end
        if (out_sat_w !== 1'b0) begin $display("FAIL wrap_flag: got %b required 0", out_sat_w); n_fail++; end
        if (score_a !== 24'sd129540) begin $display("FAIL wide_score: got %0d required 129540", score_a); n_fail++; end
        if (out_sat_a !== 1'b0) begin $display("FAIL wide_flag: got %b required 0", out_sat_a); n_fail++; end
        step();
    endtask

    task automatic test_load_handshake();
        logic [7:0] d [4];
        d = '{8'd1, 8'd2, 8'd3, 8'd4};
        do_reload();
        for (int i = 0; i < 4; i++) begin
            desc_valid = 1'b0;
            step();
            desc_valid = 1'b1;
            desc_data  = d[i];
            n_checks += 2;
            if (win_ready_a !== 1'b0) begin $display("FAIL hs_win_ready: got %b required 0 before beat %0d", win_ready_a, i); n_fail++; end
            if (desc_ready_a !== 1'b1) begin $display("FAIL hs_desc_ready: got %b required 1 at beat %0d", desc_ready_a, i); n_fail++; end
            step();
        end
        desc_data = 8'd99;
        n_checks += 2;
        if (desc_ready_a !== 1'b0) begin $display("FAIL hs_run_desc_ready: got %b required 0", desc_ready_a); n_fail++; end
        if (win_ready_a !== 1'b1) begin $display("FAIL hs_run_win_ready: got %b required 1", win_ready_a); n_fail++; end
        step();
        desc_valid = 1'b0;
        n_checks++;
        if (desc_ready_a !== 1'b0) begin $display("FAIL hs_extra_beat: desc_ready=%b required 0", desc_ready_a); n_fail++; end
        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        send(8'd30, 1'b0);
        send(8'd40, 1'b0);
        n_checks++;
        if (score_a !== 24'sd300) begin $display("FAIL hs_score300: got %0d required 300", score_a); n_fail++; end
        step();
        win_valid = 1'b1;
        win_data  = 8'd77;
        reload    = 1'b1;
        #1;
        n_checks++;
        if (win_ready_a !== 1'b0) begin $display("FAIL reload_win_ready: got %b required 0", win_ready_a); n_fail++; end
        step();
        reload    = 1'b0;
        win_valid = 1'b0;
        n_checks += 2;
        if (desc_ready_a !== 1'b1) begin $display("FAIL reload_desc_ready: got %b required 1", desc_ready_a); n_fail++; end
        if (out_valid_a !== 1'b0) begin $display("FAIL reload_valid: got %b required 0", out_valid_a); n_fail++; end
        load_desc(8'd1, 8'd2, 8'd3, 8'd4);
        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        send(8'd30, 1'b0);
        n_checks++;
        if (out_valid_a !== 1'b0) begin $display("FAIL reload_fill_cleared: out_valid=%b required 0", out_valid_a); n_fail++; end
        send(8'd40, 1'b0);
        n_checks++;
        if (score_a !== 24'sd300) begin $display("FAIL reload_score300: got %0d required 300", score_a); n_fail++; end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(8'd1, 1'b1);
        send(8'd1, 1'b0);
        send(8'd1, 1'b0);
        send(8'd1, 1'b0);
        n_checks++;
        if (out_valid_a !== 1'b1) begin $display("FAIL ar_pre_valid: got %b required 1", out_valid_a); n_fail++; end
        #2;
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (out_valid_a !== 1'b0) begin $display("FAIL ar_valid: got %b required 0", out_valid_a); n_fail++; end
        if (score_a !== 24'sd0) begin $display("FAIL ar_score: got %0d required 0", score_a); n_fail++; end
        if (desc_ready_a !== 1'b1) begin $display("FAIL ar_desc_ready: got %b required 1", desc_ready_a); n_fail++; end
        if (win_ready_a !== 1'b0) begin $display("FAIL ar_win_ready: got %b required 0", win_ready_a); n_fail++; end
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        load_desc(8'd1, 8'd2, 8'd3, 8'd4);
        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        send(8'd30, 1'b0);
        send(8'd40, 1'b0);
        n_checks += 2;
        if (out_valid_a !== 1'b1) begin $display("FAIL ar_post_valid: got %b required 1", out_valid_a); n_fail++; end
        if (score_a !== 24'sd300) begin $display("FAIL ar_score300: got %0d required 300", score_a); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_row_clear();
        test_signed_sat();
        test_load_handshake();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
